armleobus_burst_scratchmem: RTL and testbench

- Parametrised ArmleoBus slave memory model for cache and PTW benches; successor to the single-beat scratchmem.
- Adds configurable data width, depth and wait-state latency.
- Adds incrementing bursts via burstcount and a runtime fault-injection window returning UNKNOWN_ADDRESS.
- Also synthesisable as on-chip BRAM behind the bus.

---
 rtl/armleobus_pkg.sv | 18 +
 rtl/armleobus_bytemem.sv | 27 ++
 rtl/armleobus_burst_scratchmem.sv | 158 +++++++++++++++
 tb/tb_armleobus_burst_scratchmem.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleobus_pkg.sv
// ArmleoBus encodings shared by the burst scratch memory and its bench.
// Command/response codes match the single-beat scratchmem they replace.
package armleobus_pkg;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;

  localparam logic [2:0] RESP_SUCCESS           = 3'd0;
  localparam logic [2:0] RESP_UNKNOWN_ADDRESS   = 3'd2;
  localparam logic [2:0] RESP_INVALID_OPERATION = 3'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT     = 2'd1;
  localparam logic [1:0] ST_BEAT     = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

endpackage

// File: rtl/armleobus_bytemem.sv
// Single-port word array with per-byte write enables and a registered read port.
// Maps onto block RAM; contents are never reset.
module armleobus_bytemem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                    clk,
  input  logic [DEPTH_LOG2-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic                    re_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/armleobus_burst_scratchmem.sv
// ArmleoBus slave memory with wait states, incrementing bursts and a runtime
// fault window that answers UNKNOWN_ADDRESS.
module armleobus_burst_scratchmem
  import armleobus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 16,
  parameter int ADDR_WIDTH = 34,
  parameter int LATENCY    = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    transaction,
  input  logic [2:0]              cmd,
  input  logic [3:0]              burstcount,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbyte_enable,
  output logic                    transaction_done,
  output logic [2:0]              transaction_response,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    flt_en,
  input  logic [ADDR_WIDTH-1:0]   flt_base,
  input  logic [ADDR_WIDTH-1:0]   flt_limit
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int OFF       = $clog2(BYTES);
  localparam int WAIT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [1:0] ST_NEXT = (LATENCY == 0) ? ST_BEAT : ST_WAIT;

  logic [1:0]            state_q, state_d;
  logic [3:0]            beat_q, beat_d, wait_q, wait_d;
  logic [2:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [3:0]            bc_q, bc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  beat_act, beat_err;
  logic [2:0]            beat_resp;
  logic [DATA_WIDTH-1:0] beat_rdata, mem_rdata;
  logic [BYTES-1:0]      mem_we;
  logic                  mem_re;
  logic [DEPTH_LOG2-1:0] mem_addr;

  // A beat only completes while the master still holds the request.
  assign beat_act = (state_q == ST_BEAT) && transaction;

  always_comb begin
    beat_resp = RESP_SUCCESS;
    if (cmd_q != CMD_READ && cmd_q != CMD_WRITE)
      beat_resp = RESP_INVALID_OPERATION;
    else if (addr_q[OFF-1:0] != '0)
      beat_resp = RESP_INVALID_OPERATION;
    else if (32'(bc_q) + 32'd1 > 32'(MAX_BURST))
      beat_resp = RESP_INVALID_OPERATION;
    else if ((addr_q >> (DEPTH_LOG2 + OFF)) != '0)
      beat_resp = RESP_UNKNOWN_ADDRESS;
    else if (flt_en && (flt_base <= addr_q) && (addr_q <= flt_limit))
      beat_resp = RESP_UNKNOWN_ADDRESS;
  end

  assign beat_err   = (beat_resp != RESP_SUCCESS);
  assign beat_rdata = beat_err ? '0 : ((cmd_q == CMD_READ) ? mem_rdata : rdata_q);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    cmd_d   = cmd_q;
    bc_d    = bc_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (transaction) begin
          cmd_d   = cmd;
          addr_d  = address;
          bc_d    = burstcount;
          beat_d  = '0;
          wait_d  = '0;
          state_d = ST_NEXT;
        end
      end
      ST_WAIT: begin
        if (!transaction)                 state_d = ST_IDLE;
        else if (wait_q == 4'(WAIT_LAST)) state_d = ST_BEAT;
        else                              wait_d  = wait_q + 4'd1;
      end
      ST_BEAT: begin
        if (!transaction) begin
          state_d = ST_IDLE;
        end else begin
          resp_d  = beat_resp;
          rdata_d = beat_rdata;
          if (beat_err || beat_q == bc_q) begin
            state_d = ST_COOLDOWN;
          end else begin
            beat_d  = beat_q + 4'd1;
            addr_d  = addr_q + ADDR_WIDTH'(BYTES);
            wait_d  = '0;
            state_d = ST_NEXT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      resp_q  <= RESP_SUCCESS;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields are datapath; they are always reloaded in IDLE.
  always_ff @(posedge clk) begin
    cmd_q  <= cmd_d;
    bc_q   <= bc_d;
    addr_q <= addr_d;
  end

  // Reads are issued one cycle ahead using the next beat address so the
  // registered RAM output lines up with the BEAT cycle.
  assign mem_we   = (beat_act && cmd_q == CMD_WRITE && !beat_err) ? wbyte_enable : '0;
  assign mem_re   = (state_d == ST_BEAT) && (cmd_d == CMD_READ);
  assign mem_addr = (|mem_we) ? addr_q[OFF +: DEPTH_LOG2] : addr_d[OFF +: DEPTH_LOG2];

  armleobus_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .wdata_i (wdata),
    .rdata_o (mem_rdata)
  );

  assign transaction_done     = beat_act;
  assign transaction_response = beat_act ? beat_resp : resp_q;
  assign rdata                = beat_act ? beat_rdata : rdata_q;

endmodule

// File: tb/tb_armleobus_burst_scratchmem.sv
// Scoreboard bench for armleobus_burst_scratchmem: a master task issues bursts,
// the expected per-beat responses are queued, and a monitor checks every done.
module tb_armleobus_burst_scratchmem;
  import armleobus_pkg::*;

  localparam int AW  = 34;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          transaction;
  logic [2:0]    cmd;
  logic [3:0]    burstcount;
  logic [AW-1:0] address;
  logic [31:0]   wdata;
  logic [3:0]    wbyte_enable;
  logic          transaction_done;
  logic [2:0]    transaction_response;
  logic [31:0]   rdata;
  logic          flt_en;
  logic [AW-1:0] flt_base, flt_limit;

  typedef struct packed {
    logic [2:0]  resp;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] wbeat [16];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  armleobus_burst_scratchmem #(
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (16),
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT),
    .MAX_BURST  (16)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .transaction          (transaction),
    .cmd                  (cmd),
    .burstcount           (burstcount),
    .address              (address),
    .wdata                (wdata),
    .wbyte_enable         (wbyte_enable),
    .transaction_done     (transaction_done),
    .transaction_response (transaction_response),
    .rdata                (rdata),
    .flt_en               (flt_en),
    .flt_base             (flt_base),
    .flt_limit            (flt_limit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] r, input logic [31:0] d, input logic c);
    exp_t e;
    e.resp = r; e.data = d; e.chk_data = c;
    sb.push_back(e);
  endtask

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (transaction_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", transaction_done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("response", transaction_response, e.resp);
        if (e.chk_data) chk("rdata", rdata, e.data);
      end
    end
  end

  // mode 0: normal end (request held through COOLDOWN); 1: reset in the WAIT
  // after the last expected beat; 2: master drops the request there instead.
  task automatic run_txn(input logic [2:0] c, input logic [AW-1:0] a, input logic [3:0] bc,
                         input logic [3:0] be, input int nbeats, input int mode);
    int start_cyc, last_cyc, budget;
    @(posedge clk); #1;
    transaction = 1'b1; cmd = c; address = a; burstcount = bc;
    wbyte_enable = be; wdata = wbeat[0];
    start_cyc = cyc + 1;
    last_cyc = 0;
    @(posedge clk); #1;
    // Request fields must be latched: scramble them once accepted.
    cmd = ~c; address = ~a; burstcount = ~bc;
    for (int s = 0; s < nbeats; s++) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (transaction_done !== 1'b1 && budget < 40);
      if (transaction_done !== 1'b1) begin
        chk("done_timeout", transaction_done, 1'b1);
        break;
      end
      if (s == 0) chk("first_done_latency", cyc + 1 - start_cyc, LAT + 1);
      else        chk("done_spacing", cyc - last_cyc, LAT + 1);
      last_cyc = cyc;
      @(posedge clk); #1;
      if (s + 1 < 16) wdata = wbeat[s + 1];
    end
    if (mode == 1) begin
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("done_during_reset", transaction_done, 1'b0);
      end
      transaction = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
    end else if (mode == 2) begin
      transaction = 1'b0;
    end else begin
      @(posedge clk); #1;
      transaction = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; transaction = 1'b0; cmd = CMD_NONE; burstcount = '0;
    address = '0; wdata = '0; wbyte_enable = '0;
    flt_en = 1'b0; flt_base = '0; flt_limit = '0;
    for (int i = 0; i < 16; i++) wbeat[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", transaction_done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_done_after", transaction_done, 1'b0);
    chk("reset_response", transaction_response, RESP_SUCCESS);
    chk("reset_rdata", rdata, 32'h0);

    // Single-beat write then read back.
    wbeat[0] = 32'hDEADBEEF;
    push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h1000, 4'd0, 4'hF, 1, 0);
    push(RESP_SUCCESS, 32'hDEADBEEF, 1'b1);
    run_txn(CMD_READ, 34'h1000, 4'd0, 4'hF, 1, 0);

    // Partial write: lane i covers bits [8i+7:8i], so be=0101 replaces bytes 0 and 2.
    wbeat[0] = 32'h11223344;
    push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h1004, 4'd0, 4'hF, 1, 0);
    wbeat[0] = 32'hAABBCCDD;
    push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h1004, 4'd0, 4'b0101, 1, 0);
    push(RESP_SUCCESS, 32'h11BB33DD, 1'b1);
    run_txn(CMD_READ, 34'h1004, 4'd0, 4'hF, 1, 0);

    // Four-beat burst write and read.
    for (int i = 0; i < 4; i++) wbeat[i] = 32'(i + 1);
    for (int i = 0; i < 4; i++) push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h2000, 4'd3, 4'hF, 4, 0);
    for (int i = 0; i < 4; i++) push(RESP_SUCCESS, 32'(i + 1), 1'b1);
    run_txn(CMD_READ, 34'h2000, 4'd3, 4'hF, 4, 0);

    // Fault window over the third word of a burst.
    for (int i = 0; i < 4; i++) wbeat[i] = 32'(16 + i);
    for (int i = 0; i < 4; i++) push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h3000, 4'd3, 4'hF, 4, 0);
    flt_en = 1'b1; flt_base = 34'h3008; flt_limit = 34'h300F;
    push(RESP_SUCCESS, 32'd16, 1'b1);
    push(RESP_SUCCESS, 32'd17, 1'b1);
    push(RESP_UNKNOWN_ADDRESS, 32'd0, 1'b1);
    run_txn(CMD_READ, 34'h3000, 4'd3, 4'hF, 3, 0);
    for (int i = 0; i < 4; i++) wbeat[i] = 32'(32 + i);
    push(RESP_SUCCESS, '0, 1'b0);
    push(RESP_SUCCESS, '0, 1'b0);
    push(RESP_UNKNOWN_ADDRESS, 32'd0, 1'b1);
    run_txn(CMD_WRITE, 34'h3000, 4'd3, 4'hF, 3, 0);
    flt_en = 1'b0;
    push(RESP_SUCCESS, 32'd32, 1'b1);
    push(RESP_SUCCESS, 32'd33, 1'b1);
    push(RESP_SUCCESS, 32'd18, 1'b1);
    push(RESP_SUCCESS, 32'd19, 1'b1);
    run_txn(CMD_READ, 34'h3000, 4'd3, 4'hF, 4, 0);

    // Invalid operations and out-of-range addresses.
    push(RESP_INVALID_OPERATION, 32'd0, 1'b1);
    run_txn(CMD_READ, 34'h1002, 4'd0, 4'hF, 1, 0);
    wbeat[0] = 32'h0BADF00D;
    push(RESP_INVALID_OPERATION, 32'd0, 1'b1);
    run_txn(3'd7, 34'h1000, 4'd3, 4'hF, 1, 0);
    push(RESP_UNKNOWN_ADDRESS, 32'd0, 1'b1);
    run_txn(CMD_READ, 34'h4_0000, 4'd0, 4'hF, 1, 0);
    push(RESP_UNKNOWN_ADDRESS, 32'd0, 1'b1);
    run_txn(CMD_READ, 34'h2_0000_1000, 4'd0, 4'hF, 1, 0);

    // Bursts running off the top of memory.
    wbeat[0] = 32'h88; wbeat[1] = 32'h99;
    push(RESP_SUCCESS, '0, 1'b0);
    push(RESP_UNKNOWN_ADDRESS, 32'd0, 1'b1);
    run_txn(CMD_WRITE, 34'h3_FFFC, 4'd1, 4'hF, 2, 0);
    push(RESP_SUCCESS, 32'h88, 1'b1);
    push(RESP_UNKNOWN_ADDRESS, 32'd0, 1'b1);
    run_txn(CMD_READ, 34'h3_FFFC, 4'd1, 4'hF, 2, 0);

    // Reset during the WAIT before beat 2 of a write burst.
    wbeat[0] = 32'h55;
    push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h5008, 4'd0, 4'hF, 1, 0);
    push(RESP_SUCCESS, 32'hDEADBEEF, 1'b1);
    run_txn(CMD_READ, 34'h1000, 4'd0, 4'hF, 1, 0);
    wbeat[0] = 32'hA1; wbeat[1] = 32'hB2; wbeat[2] = 32'hC3; wbeat[3] = 32'hD4;
    push(RESP_SUCCESS, '0, 1'b0);
    push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h5000, 4'd3, 4'hF, 2, 1);
    @(negedge clk);
    chk("post_reset_done", transaction_done, 1'b0);
    chk("post_reset_response", transaction_response, RESP_SUCCESS);
    chk("post_reset_rdata", rdata, 32'h0);
    push(RESP_SUCCESS, 32'hA1, 1'b1);
    push(RESP_SUCCESS, 32'hB2, 1'b1);
    push(RESP_SUCCESS, 32'h55, 1'b1);
    run_txn(CMD_READ, 34'h5000, 4'd2, 4'hF, 3, 0);

    // Master drops the request mid-burst: the second beat is never written.
    wbeat[0] = 32'h60;
    push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h6004, 4'd0, 4'hF, 1, 0);
    wbeat[0] = 32'h61; wbeat[1] = 32'h62;
    push(RESP_SUCCESS, '0, 1'b0);
    run_txn(CMD_WRITE, 34'h6000, 4'd1, 4'hF, 1, 2);
    push(RESP_SUCCESS, 32'h61, 1'b1);
    push(RESP_SUCCESS, 32'h60, 1'b1);
    run_txn(CMD_READ, 34'h6000, 4'd1, 4'hF, 2, 0);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
